// File: rtl/hazard_if.sv
// Handshake bundle between the pipeline datapath and hazard_ctrl.
// master = datapath side, slave = hazard controller.
interface hazard_if;
  logic [4:0]  IF_ID_Rs;
  logic [4:0]  IF_ID_Rt;
  logic        ID_EX_MemRead;
  logic [4:0]  ID_EX_Rt;
  logic        EX_MEM_Branch;
  logic        EX_MEM_ALU_zero;
  logic        EX_MEM_Jump;
  logic        EX_MEM_MemRead;
  logic        EX_MEM_MemWrite;
  logic        dmem_ready;
  logic        dmem_req;
  logic        pipe_hold;
  logic        PC_Write;
  logic        IF_ID_Write;
  logic        IF_Flush;
  logic        ID_Flush;
  logic        EX_Flush;
  logic [1:0]  PCSrc;
  logic        mem_err;
  logic [31:0] stall_cnt;
  logic [31:0] flush_cnt;
  logic [31:0] wait_cnt;

  modport master (
    output IF_ID_Rs, IF_ID_Rt,
    output ID_EX_MemRead, ID_EX_Rt,
    output EX_MEM_Branch, EX_MEM_ALU_zero,
    output EX_MEM_Jump,
    output EX_MEM_MemRead, EX_MEM_MemWrite,
    output dmem_ready,
    input  dmem_req, pipe_hold,
    input  PC_Write, IF_ID_Write,
    input  IF_Flush, ID_Flush, EX_Flush,
    input  PCSrc, mem_err,
    input  stall_cnt, flush_cnt, wait_cnt
  );

  modport slave (
    input  IF_ID_Rs, IF_ID_Rt,
    input  ID_EX_MemRead, ID_EX_Rt,
    input  EX_MEM_Branch, EX_MEM_ALU_zero,
    input  EX_MEM_Jump,
    input  EX_MEM_MemRead, EX_MEM_MemWrite,
    input  dmem_ready,
    output dmem_req, pipe_hold,
    output PC_Write, IF_ID_Write,
    output IF_Flush, ID_Flush, EX_Flush,
    output PCSrc, mem_err,
    output stall_cnt, flush_cnt, wait_cnt
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Hazard/sequencing controller: load-use stall, MEM redirect, dmem wait.
// Define HAZARD_PERF_CNT_EN to build the stall/flush/wait counters.
module hazard_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input logic     clk,
  input logic     rst,
  hazard_if.slave hz
);

  typedef enum logic {RUN, MWAIT} state_t;

  localparam logic [7:0] WLAST = 8'(MEM_TIMEOUT - 1);

  state_t     state;
  logic [7:0] wcnt;
  logic       mem_err_q;

  logic mem_op;
  logic rdy;
  logic timeout;
  logic hold;
  logic redirect;
  logic load_use;
  logic redir_act;
  logic stall_act;

  always_comb begin
    mem_op  = hz.EX_MEM_MemRead | hz.EX_MEM_MemWrite;
    rdy     = hz.dmem_ready;
    timeout = (state == MWAIT) & (wcnt == WLAST) & ~rdy;

    hold = 1'b0;
    if (!rst) begin
      unique case (state)
        RUN:   hold = mem_op & ~rdy;
        MWAIT: hold = ~rdy & ~timeout;
      endcase
    end

    redirect = hz.EX_MEM_Jump |
               (hz.EX_MEM_Branch & hz.EX_MEM_ALU_zero);
    load_use = hz.ID_EX_MemRead &
               (hz.ID_EX_Rt != 5'd0) &
               ((hz.ID_EX_Rt == hz.IF_ID_Rs) |
                (hz.ID_EX_Rt == hz.IF_ID_Rt));

    // Mutually exclusive qualifiers encode the priority order
    redir_act = ~rst & ~hold & redirect;
    stall_act = ~rst & ~hold & ~redirect & load_use;
  end

  always_comb begin
    hz.dmem_req    = ~rst & mem_op;
    hz.pipe_hold   = hold;
    hz.PC_Write    = 1'b1;
    hz.IF_ID_Write = 1'b1;
    hz.IF_Flush    = 1'b0;
    hz.ID_Flush    = 1'b0;
    hz.EX_Flush    = 1'b0;
    hz.PCSrc       = 2'b00;
    unique case (1'b1)
      hold: begin
        hz.PC_Write    = 1'b0;
        hz.IF_ID_Write = 1'b0;
      end
      redir_act: begin
        hz.IF_Flush = 1'b1;
        hz.ID_Flush = 1'b1;
        hz.EX_Flush = 1'b1;
        hz.PCSrc    = hz.EX_MEM_Jump ? 2'b10 : 2'b01;
      end
      stall_act: begin
        hz.PC_Write    = 1'b0;
        hz.IF_ID_Write = 1'b0;
        hz.ID_Flush    = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= RUN;
      wcnt      <= 8'd0;
      mem_err_q <= 1'b0;
    end else begin
      unique case (state)
        RUN: begin
          if (mem_op & ~rdy) begin
            state <= MWAIT;
            wcnt  <= 8'd0;
          end
        end
        MWAIT: begin
          wcnt <= wcnt + 8'd1;
          if (rdy | timeout) state <= RUN;
          if (timeout) mem_err_q <= 1'b1;
        end
      endcase
    end
  end

  assign hz.mem_err = mem_err_q;

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_q;
  logic [31:0] flush_q;
  logic [31:0] wait_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= '0;
      flush_q <= '0;
      wait_q  <= '0;
    end else begin
      if (stall_act) stall_q <= stall_q + 32'd1;
      if (redir_act) flush_q <= flush_q + 32'd1;
      if (hold)      wait_q  <= wait_q + 32'd1;
    end
  end

  assign hz.stall_cnt = stall_q;
  assign hz.flush_cnt = flush_q;
  assign hz.wait_cnt  = wait_q;
`else
  assign hz.stall_cnt = '0;
  assign hz.flush_cnt = '0;
  assign hz.wait_cnt  = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl with MEM_TIMEOUT = 4.
// Counter expectations follow HAZARD_PERF_CNT_EN.
module tb_hazard_ctrl;

`ifdef HAZARD_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  hazard_if hz ();

  hazard_ctrl #(.MEM_TIMEOUT(4)) dut (
    .clk (clk),
    .rst (rst),
    .hz  (hz)
  );

  initial forever #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic ctl(input string tag,
                     input logic h, input logic pw,
                     input logic iw, input logic fi,
                     input logic fd, input logic fe,
                     input logic [1:0] ps, input logic rq);
    chk({tag, ".hold"}, 32'(hz.pipe_hold), 32'(h));
    chk({tag, ".pcw"},  32'(hz.PC_Write), 32'(pw));
    chk({tag, ".ifw"},  32'(hz.IF_ID_Write), 32'(iw));
    chk({tag, ".iff"},  32'(hz.IF_Flush), 32'(fi));
    chk({tag, ".idf"},  32'(hz.ID_Flush), 32'(fd));
    chk({tag, ".exf"},  32'(hz.EX_Flush), 32'(fe));
    chk({tag, ".pcsrc"}, 32'(hz.PCSrc), 32'(ps));
    chk({tag, ".req"},  32'(hz.dmem_req), 32'(rq));
  endtask

  task automatic cnt(input string tag, input int s,
                     input int f, input int w);
    chk({tag, ".stall_cnt"}, hz.stall_cnt, PERF ? 32'(s) : 32'd0);
    chk({tag, ".flush_cnt"}, hz.flush_cnt, PERF ? 32'(f) : 32'd0);
    chk({tag, ".wait_cnt"},  hz.wait_cnt,  PERF ? 32'(w) : 32'd0);
  endtask

  task automatic set_in(input logic lmr, input logic [4:0] lrt,
                        input logic [4:0] rs, input logic [4:0] rt,
                        input logic br, input logic z,
                        input logic jp, input logic mr,
                        input logic mw, input logic rdy);
    hz.ID_EX_MemRead   = lmr;
    hz.ID_EX_Rt        = lrt;
    hz.IF_ID_Rs        = rs;
    hz.IF_ID_Rt        = rt;
    hz.EX_MEM_Branch   = br;
    hz.EX_MEM_ALU_zero = z;
    hz.EX_MEM_Jump     = jp;
    hz.EX_MEM_MemRead  = mr;
    hz.EX_MEM_MemWrite = mw;
    hz.dmem_ready      = rdy;
    #1;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    // reset forces defaults even with every hazard input active
    rst = 1'b1;
    set_in(1, 5'd8, 5'd8, 0, 1, 1, 0, 1, 0, 0);
    ctl("rst", 0, 1, 1, 0, 0, 0, 2'b00, 0);
    tick;
    tick;
    rst = 1'b0;
    idle;
    chk("rst.mem_err", 32'(hz.mem_err), 32'd0);
    cnt("rst", 0, 0, 0);
    ctl("idle", 0, 1, 1, 0, 0, 0, 2'b00, 0);

    // load-use on Rs
    set_in(1, 5'd8, 5'd8, 5'd3, 0, 0, 0, 0, 0, 0);
    ctl("lu_rs", 0, 0, 0, 0, 1, 0, 2'b00, 0);
    tick;
    // load now in MEM, zero-wait
    set_in(0, 5'd0, 5'd8, 5'd3, 0, 0, 0, 1, 0, 1);
    ctl("lu_next", 0, 1, 1, 0, 0, 0, 2'b00, 1);
    tick;
    // load-use on Rt
    set_in(1, 5'd9, 5'd1, 5'd9, 0, 0, 0, 0, 0, 0);
    ctl("lu_rt", 0, 0, 0, 0, 1, 0, 2'b00, 0);
    tick;
    // r0 never stalls
    set_in(1, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, 0);
    ctl("lu_r0", 0, 1, 1, 0, 0, 0, 2'b00, 0);
    tick;
    set_in(0, 5'd8, 5'd8, 5'd8, 0, 0, 0, 0, 0, 0);
    ctl("lu_noload", 0, 1, 1, 0, 0, 0, 2'b00, 0);
    tick;
    cnt("lu", 2, 0, 0);

    // branch taken / not taken
    set_in(0, 0, 0, 0, 1, 1, 0, 0, 0, 0);
    ctl("br_taken", 0, 1, 1, 1, 1, 1, 2'b01, 0);
    tick;
    set_in(0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    ctl("br_nt", 0, 1, 1, 0, 0, 0, 2'b00, 0);
    tick;
    // jump + branch + load-use: jump wins
    set_in(1, 5'd4, 5'd4, 0, 1, 1, 1, 0, 0, 0);
    ctl("jmp_br", 0, 1, 1, 1, 1, 1, 2'b10, 0);
    tick;
    cnt("br", 2, 2, 0);

    // memory wait with pending branch and load-use
    set_in(1, 5'd5, 5'd5, 0, 1, 1, 0, 1, 0, 0);
    ctl("mw_enter", 1, 0, 0, 0, 0, 0, 2'b00, 1);
    tick;
    ctl("mw_w0", 1, 0, 0, 0, 0, 0, 2'b00, 1);
    tick;
    ctl("mw_w1", 1, 0, 0, 0, 0, 0, 2'b00, 1);
    tick;
    ctl("mw_w2", 1, 0, 0, 0, 0, 0, 2'b00, 1);
    tick;
    // ready arrives in the last allowed cycle
    set_in(1, 5'd5, 5'd5, 0, 1, 1, 0, 1, 0, 1);
    ctl("mw_ready", 0, 1, 1, 1, 1, 1, 2'b01, 1);
    tick;
    idle;
    ctl("mw_run", 0, 1, 1, 0, 0, 0, 2'b00, 0);
    chk("mw.mem_err", 32'(hz.mem_err), 32'd0);
    cnt("mw", 2, 3, 4);

    // zero-wait store
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    ctl("st_zw", 0, 1, 1, 0, 0, 0, 2'b00, 1);
    tick;

    // timeout
    set_in(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    ctl("to_enter", 1, 0, 0, 0, 0, 0, 2'b00, 1);
    tick;
    ctl("to_w0", 1, 0, 0, 0, 0, 0, 2'b00, 1);
    tick;
    ctl("to_w1", 1, 0, 0, 0, 0, 0, 2'b00, 1);
    tick;
    ctl("to_w2", 1, 0, 0, 0, 0, 0, 2'b00, 1);
    tick;
    ctl("to_last", 0, 1, 1, 0, 0, 0, 2'b00, 1);
    chk("to_last.mem_err", 32'(hz.mem_err), 32'd0);
    tick;
    idle;
    chk("to.mem_err", 32'(hz.mem_err), 32'd1);
    ctl("to_run", 0, 1, 1, 0, 0, 0, 2'b00, 0);
    cnt("to", 2, 3, 8);
    tick;
    chk("to.sticky", 32'(hz.mem_err), 32'd1);

    // reset in the 2nd MWAIT cycle
    set_in(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    ctl("rw_enter", 1, 0, 0, 0, 0, 0, 2'b00, 1);
    tick;
    ctl("rw_w0", 1, 0, 0, 0, 0, 0, 2'b00, 1);
    tick;
    rst = 1'b1;
    #1;
    ctl("rw_rst", 0, 1, 1, 0, 0, 0, 2'b00, 0);
    tick;
    rst = 1'b0;
    idle;
    ctl("rw_run", 0, 1, 1, 0, 0, 0, 2'b00, 0);
    chk("rw.mem_err", 32'(hz.mem_err), 32'd0);
    cnt("rw", 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
